// File: rtl/u_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package u_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 30;
    localparam int unsigned DATA_W_DEF = 32;

    // Grant identifiers, also the encoding of last_grant
    localparam logic GNT_INS  = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        INS_BUSY,
        DATA_BUSY
    } arb_state_e;

endpackage

// File: rtl/u_mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory bridge bus around u_mem_arbiter.
// slave  : the arbiter's view (requests in, stalls/read data/bus command out).
// master : the surrounding pipeline front ends and bridge.
interface u_mem_arbiter_if
    import u_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic                  ins_req_i;
    logic [ADDR_W-1:0]     ins_addr_i;
    logic                  ins_flush_i;
    logic [DATA_W-1:0]     ins_rdata_o;
    logic                  ins_busywait_o;

    logic                  data_req_i;
    logic                  data_we_i;
    logic [ADDR_W-1:0]     data_addr_i;
    logic [DATA_W-1:0]     data_wdata_i;
    logic [DATA_W/8-1:0]   data_be_i;
    logic [DATA_W-1:0]     data_rdata_o;
    logic                  data_busywait_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic                  mem_ack_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  ins_req_i, ins_addr_i, ins_flush_i,
        output ins_rdata_o, ins_busywait_o,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
        output data_rdata_o, data_busywait_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output ins_req_i, ins_addr_i, ins_flush_i,
        input  ins_rdata_o, ins_busywait_o,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i, data_be_i,
        input  data_rdata_o, data_busywait_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/u_mem_arbiter_pick.sv
// Combinational grant selection for u_mem_arbiter.
// Build option MEM_ARB_FAIR_EN: round-robin on ties instead of data-first priority.
module u_mem_arb_pick
    import u_mem_pkg::*;
(
    input  logic ins_req,
    input  logic data_req,
    input  logic ins_done,
    input  logic data_done,
    input  logic ins_flush,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    logic ins_ok;
    logic data_ok;

    // A requester just completed (done) is not re-granted; a fetch being flushed is held off
    always_comb begin
        ins_ok    = ins_req & ~ins_done & ~ins_flush;
        data_ok   = data_req & ~data_done;
        gnt_valid = ins_ok | data_ok;
        gnt_id    = GNT_INS;
        if (ins_ok && data_ok) begin
`ifdef MEM_ARB_FAIR_EN
            gnt_id = (last_grant == GNT_INS) ? GNT_DATA : GNT_INS;
`else
            gnt_id = GNT_DATA;
`endif
        end else if (data_ok) begin
            gnt_id = GNT_DATA;
        end
    end

`ifndef MEM_ARB_FAIR_EN
    // Fixed priority ignores the grant history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/u_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch (read-only)
// and data access (read/write). Registered bus command, registered read data,
// one-cycle done flags, discard of flushed fetches.
// Build option MEM_ARB_FAIR_EN selects round-robin tie-break (see u_mem_arb_pick).
module u_mem_arbiter
    import u_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    u_mem_arbiter_if.slave bus
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic                gnt_valid;
    logic                gnt_id;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;
    logic [DATA_W-1:0]   ins_rdata;
    logic [DATA_W-1:0]   data_rdata;
    logic                ins_done;
    logic                data_done;
    logic                discard;
    logic                last_grant;

    u_mem_arb_pick u_pick (
        .ins_req    (bus.ins_req_i),
        .data_req   (bus.data_req_i),
        .ins_done   (ins_done),
        .data_done  (data_done),
        .ins_flush  (bus.ins_flush_i),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: grant from IDLE, return to IDLE on ack (never straight to a new grant)
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:                if (gnt_valid) state_nxt = (gnt_id == GNT_DATA) ? DATA_BUSY : INS_BUSY;
            INS_BUSY, DATA_BUSY: if (bus.mem_ack_i) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Bus command load/hold, read-data capture, done pulses and flush discard
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            ins_rdata  <= '0;
            data_rdata <= '0;
            ins_done   <= 1'b0;
            data_done  <= 1'b0;
            discard    <= 1'b0;
            last_grant <= GNT_INS;
        end else begin
            ins_done  <= 1'b0;
            data_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        mem_req    <= 1'b1;
                        last_grant <= gnt_id;
                        if (gnt_id == GNT_DATA) begin
                            mem_we    <= bus.data_we_i;
                            mem_addr  <= bus.data_addr_i;
                            mem_wdata <= bus.data_wdata_i;
                            mem_be    <= bus.data_be_i;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= bus.ins_addr_i;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                INS_BUSY: begin
                    if (bus.mem_ack_i) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        // A flush landing on the ack cycle also kills the response
                        if (!(discard || bus.ins_flush_i)) begin
                            ins_rdata <= bus.mem_rdata_i;
                            ins_done  <= 1'b1;
                        end
                    end else if (bus.ins_flush_i) begin
                        discard <= 1'b1;
                    end
                end
                DATA_BUSY: begin
                    if (bus.mem_ack_i) begin
                        mem_req   <= 1'b0;
                        data_done <= 1'b1;
                        if (!mem_we) data_rdata <= bus.mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: stalls from registered done flags, registered bus command and read data
    always_comb begin
        bus.ins_busywait_o  = bus.ins_req_i & ~ins_done;
        bus.data_busywait_o = bus.data_req_i & ~data_done;
        bus.ins_rdata_o     = ins_rdata;
        bus.data_rdata_o    = data_rdata;
        bus.mem_req_o       = mem_req;
        bus.mem_we_o        = mem_we;
        bus.mem_addr_o      = mem_addr;
        bus.mem_wdata_o     = mem_wdata;
        bus.mem_be_o        = mem_be;
    end

endmodule

// File: tb/tb_u_mem_arbiter.sv
// Directed self-checking bench for u_mem_arbiter; bus commands are checked
// against a queue of expected commands pushed as stimulus is applied.
module tb_u_mem_arbiter;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    u_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    u_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] be;
    } cmd_t;

    cmd_t            exp_q[$];
    int              n_asserts = 0;
    int              n_fails   = 0;
    int              ack_dly   = 0;
    logic [DW-1:0]   mem_img [logic [AW-1:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.be = be;
        exp_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Wait for the selected port's busywait to drop; cyc = stalled cycles seen
    task automatic wait_done(input bit is_data, input int max_cyc, input bit other_high, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (other_high)
                check(is_data ? "ins_stalled" : "data_stalled",
                      64'(is_data ? bus.ins_busywait_o : bus.data_busywait_o), 64'd1);
            if ((is_data ? bus.data_busywait_o : bus.ins_busywait_o) === 1'b0) return;
            cyc++;
            if (cyc >= max_cyc) begin
                check(is_data ? "data_done_timeout" : "ins_done_timeout", 64'(cyc), 64'd0);
                return;
            end
        end
    endtask

    task automatic wait_mem_req(input int max_cyc);
        int cyc = 0;
        forever begin
            @(negedge clk_i);
            if (bus.mem_req_o === 1'b1) return;
            cyc++;
            if (cyc >= max_cyc) begin
                check("mem_req_timeout", 64'(cyc), 64'd0);
                return;
            end
        end
    endtask

    // Memory bridge model: ack ack_dly cycles after mem_req_o is first seen
    initial begin
        int cnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o === 1'b1) begin
                if (cnt >= ack_dly) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = mem_img.exists(bus.mem_addr_o) ? mem_img[bus.mem_addr_o]
                                                                      : 32'hBAD0_0000;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: each new bus command must match the oldest expected one
    initial begin
        logic prev = 1'b0;
        cmd_t e;
        forever begin
            @(negedge clk_i);
            if (bus.mem_req_o === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    check("cmd_we", 64'(bus.mem_we_o), 64'(e.we));
                    if (e.we) begin
                        check("cmd_wdata", 64'(bus.mem_wdata_o), 64'(e.wdata));
                        check("cmd_be", 64'(bus.mem_be_o), 64'(e.be));
                    end
                end
            end
            prev = bus.mem_req_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit first_data;
        logic [DW-1:0] old_rd;

        rst_i            = 1'b1;
        bus.ins_req_i    = 1'b0;
        bus.ins_addr_i   = '0;
        bus.ins_flush_i  = 1'b0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.data_be_i    = '0;

        // Reset state
        repeat (3) step();
        @(negedge clk_i);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("rst_ins_rdata", 64'(bus.ins_rdata_o), 64'd0);
        check("rst_data_rdata", 64'(bus.data_rdata_o), 64'd0);
        check("rst_ins_bw", 64'(bus.ins_busywait_o), 64'd0);
        step();
        rst_i = 1'b0;
        step();

        // Fetch only, ack 3 cycles after mem_req_o
        mem_img[30'h10] = 32'h0000_0013;
        ack_dly = 3;
        push_cmd(1'b0, 30'h10, '0, '0);
        bus.ins_addr_i = 30'h10;
        bus.ins_req_i  = 1'b1;
        wait_done(1'b0, 20, 1'b0, cyc);
        check("fetch_latency", 64'(cyc), 64'd5);
        check("fetch_rdata", 64'(bus.ins_rdata_o), 64'h13);
        step();
        check("fetch_bw_one_cycle", 64'(bus.ins_busywait_o), 64'd1);
        bus.ins_req_i = 1'b0;
        check("fetch_data_rdata", 64'(bus.data_rdata_o), 64'd0);

        // Both request together: data first, fetch stalled throughout
        mem_img[30'h30] = 32'h3333_0030;
        mem_img[30'h34] = 32'h3434_0034;
        ack_dly = 1;
        push_cmd(1'b0, 30'h30, '0, '0);
        push_cmd(1'b0, 30'h34, '0, '0);
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 30'h30;
        bus.data_req_i  = 1'b1;
        bus.ins_addr_i  = 30'h34;
        bus.ins_req_i   = 1'b1;
        wait_done(1'b1, 20, 1'b1, cyc);
        check("tie_data_rdata", 64'(bus.data_rdata_o), 64'h3333_0030);
        step();
        bus.data_req_i = 1'b0;
        wait_done(1'b0, 20, 1'b0, cyc);
        check("tie_ins_rdata", 64'(bus.ins_rdata_o), 64'h3434_0034);
        step();
        bus.ins_req_i = 1'b0;

        // Both held for four transactions: DATA, INS, DATA, INS
        ack_dly = 0;
        for (int i = 0; i < 4; i++)
            push_cmd(1'b0, (i % 2 == 0) ? 30'h30 : 30'h34, '0, '0);
        bus.data_req_i = 1'b1;
        bus.ins_req_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done((i % 2 == 0), 20, (i != 3), cyc);
            if (i % 2 == 0) check("alt_data_rdata", 64'(bus.data_rdata_o), 64'h3333_0030);
            else            check("alt_ins_rdata", 64'(bus.ins_rdata_o), 64'h3434_0034);
            if (i == 2) begin
                step();
                bus.data_req_i = 1'b0;
            end
        end
        step();
        bus.ins_req_i = 1'b0;

        // Flush of an in-flight fetch: response discarded, new PC served
        old_rd = 32'h3434_0034;
        mem_img[30'h40] = 32'hDEAD_BEEF;
        mem_img[30'h50] = 32'h5050_5050;
        ack_dly = 3;
        push_cmd(1'b0, 30'h40, '0, '0);
        bus.ins_addr_i = 30'h40;
        bus.ins_req_i  = 1'b1;
        wait_mem_req(20);
        step();
        bus.ins_flush_i = 1'b1;
        step();
        bus.ins_flush_i = 1'b0;
        push_cmd(1'b0, 30'h50, '0, '0);
        bus.ins_addr_i = 30'h50;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("flush_no_done", 64'(bus.ins_busywait_o), 64'd1);
            check("flush_rdata_kept", 64'(bus.ins_rdata_o), 64'(old_rd));
            if (bus.mem_req_o === 1'b0) break;
        end
        wait_done(1'b0, 20, 1'b0, cyc);
        check("flush_new_rdata", 64'(bus.ins_rdata_o), 64'h5050_5050);
        step();
        bus.ins_req_i = 1'b0;

        // Data write: command carries we/be/wdata, read data untouched
        ack_dly = 1;
        push_cmd(1'b1, 30'h20, 32'hA5A5_A5A5, 4'b0011);
        bus.data_we_i    = 1'b1;
        bus.data_addr_i  = 30'h20;
        bus.data_wdata_i = 32'hA5A5_A5A5;
        bus.data_be_i    = 4'b0011;
        bus.data_req_i   = 1'b1;
        wait_done(1'b1, 20, 1'b0, cyc);
        check("write_rdata_kept", 64'(bus.data_rdata_o), 64'h3333_0030);
        step();
        bus.data_req_i = 1'b0;
        bus.data_we_i  = 1'b0;

        // Tie right after a data grant; minimum latency with immediate ack
`ifdef MEM_ARB_FAIR_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        mem_img[30'h60] = 32'h6060_6060;
        mem_img[30'h64] = 32'h6464_6464;
        ack_dly = 0;
        if (first_data) begin
            push_cmd(1'b0, 30'h60, '0, '0);
            push_cmd(1'b0, 30'h64, '0, '0);
        end else begin
            push_cmd(1'b0, 30'h64, '0, '0);
            push_cmd(1'b0, 30'h60, '0, '0);
        end
        bus.data_addr_i = 30'h60;
        bus.ins_addr_i  = 30'h64;
        bus.data_req_i  = 1'b1;
        bus.ins_req_i   = 1'b1;
        wait_done(first_data, 20, 1'b1, cyc);
        check("min_latency", 64'(cyc), 64'd2);
        step();
        if (first_data) bus.data_req_i = 1'b0;
        else            bus.ins_req_i  = 1'b0;
        wait_done(!first_data, 20, 1'b0, cyc);
        check("tie2_data_rdata", 64'(bus.data_rdata_o), 64'h6060_6060);
        check("tie2_ins_rdata", 64'(bus.ins_rdata_o), 64'h6464_6464);
        step();
        bus.data_req_i = 1'b0;
        bus.ins_req_i  = 1'b0;

        // Reset during DATA_BUSY abandons the transaction
        ack_dly = 6;
        push_cmd(1'b0, 30'h70, '0, '0);
        bus.data_addr_i = 30'h70;
        bus.data_req_i  = 1'b1;
        wait_mem_req(20);
        step();
        bus.ins_addr_i = 30'h74;
        bus.ins_req_i  = 1'b1;
        rst_i          = 1'b1;
        step();
        @(negedge clk_i);
        check("midrst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("midrst_data_bw", 64'(bus.data_busywait_o), 64'd1);
        check("midrst_ins_bw", 64'(bus.ins_busywait_o), 64'd1);
        check("midrst_data_rdata", 64'(bus.data_rdata_o), 64'd0);
        bus.data_req_i = 1'b0;
        bus.ins_req_i  = 1'b0;
        #1;
        check("midrst_data_bw_low", 64'(bus.data_busywait_o), 64'd0);
        check("midrst_ins_bw_low", 64'(bus.ins_busywait_o), 64'd0);
        step();
        rst_i = 1'b0;
        repeat (3) step();
        @(negedge clk_i);
        check("post_rst_idle", 64'(bus.mem_req_o), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
